seg_serial_tx: RTL
==================

# seg_serial_tx

Parallel-to-serial transmitter for the 64-bit segment pattern produced by the hex-to-7-segment encoder. It is the consuming end of the SEG_TXT bus. On a start request it captures the pattern and shifts it out bit-serially to the board's cascaded segment shift registers. A latch pulse then transfers the pattern to the display outputs. It sits between the segment encoder and the top-level display pins.

## Interface
- CLK_DIV, default 2: cycles per half serial-clock period; legal range ≥1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request to transmit; sampled only in IDLE.
- SEG_TXT  in  64  segment pattern, 8 digits × {a,b,c,d,e,f,g,p}.
- seg_clk  out  1  serial shift clock to the external shift registers.
- seg_sout  out  1  serial data; valid while seg_clk rises.
- seg_latch  out  1  output-latch strobe, active-high.
- busy  out  1  high from capture until transfer completes.
- done  out  1  one-cycle pulse on completion.

## Operation
- All outputs and the 64-bit shadow register are registered.
- Reset values: seg_clk=0, seg_sout=0, seg_latch=0, busy=0, done=0, shadow=0, state=IDLE.
- States and transitions:
  - IDLE: on start=1, load shadow←SEG_TXT, clear the bit counter, go to SHIFT_LO.
  - SHIFT_LO: seg_clk=0 and seg_sout=shadow[bit]. After CLK_DIV cycles, go to SHIFT_HI.
  - SHIFT_HI: seg_clk=1 and seg_sout held. After CLK_DIV cycles:
    - if bit=63, go to LATCH;
    - else bit+1 and go to SHIFT_LO.
  - LATCH: seg_clk=0, seg_latch=1, seg_sout=0. After CLK_DIV cycles, go to DONE.
  - DONE: one cycle with done=1, busy=0, seg_latch=0. The block behaves as IDLE in this cycle, so a start here is accepted.
- Bit order is LSB first: SEG_TXT[0] is sent first and SEG_TXT[63] last.
- busy=1 in SHIFT_LO, SHIFT_HI and LATCH. busy=0 in IDLE and DONE.
- Counters:
  - phase counter of width max(1,clog2(CLK_DIV)), counting 0..CLK_DIV-1 and wrapping;
  - 6-bit bit counter, counting 0..63 with no wrap past 63.
- SEG_TXT changes while busy are ignored; the shadow register is frozen until the next capture.
- start while busy is ignored and not queued.
- Reset mid-operation aborts the transfer immediately. No latch pulse and no done pulse are issued, and all outputs return to reset values asynchronously.

## Timing
- Let edge E0 be the edge at which start=1 is sampled in IDLE.
- From E0+1, busy=1, seg_clk=0 and seg_sout=SEG_TXT[0] (the value sampled at E0).
- Each bit occupies exactly 2·CLK_DIV cycles: CLK_DIV low, then CLK_DIV high.
- seg_sout changes only on entry to SHIFT_LO, i.e. with seg_clk low. Setup to the seg_clk rise is CLK_DIV cycles and hold after the rise is CLK_DIV cycles.
- Shift phase: 128·CLK_DIV cycles. Latch phase: CLK_DIV cycles.
- done=1 in cycle E0 + 129·CLK_DIV + 1, with busy=0 in that same cycle.
- Minimum start-to-start period is 129·CLK_DIV + 1 cycles (back-to-back start held high).
- Exactly 64 rising edges of seg_clk and one seg_latch pulse occur per transfer.

## Test plan
- CLK_DIV=1, SEG_TXT=64'h0000_0000_0000_0001, single start pulse:
  - seg_sout=1 during the first bit only;
  - 64 seg_clk rises;
  - seg_latch high 1 cycle;
  - done at E0+130.
- CLK_DIV=3, SEG_TXT=64'hA5C3_0FF0_1234_FEDC:
  - a bench shift-register model clocked on seg_clk and captured on seg_latch equals the input word;
  - high and low seg_clk widths are each exactly 3 cycles.
- Change SEG_TXT to all-ones and pulse start again during bit 10 of a transfer of 64'h0:
  - the captured word is all zeros;
  - no second transfer occurs.
- start held high continuously, CLK_DIV=2:
  - transfers repeat with done pulses exactly 259 cycles apart;
  - seg_latch never overlaps a seg_clk rise.
- Assert rst_n low during bit 40:
  - all outputs go to 0 asynchronously;
  - no seg_latch or done pulse;
  - after release, the next start produces a full 64-bit transfer.
- CLK_DIV=1, all-ones pattern:
  - seg_sout stays 1 across all 64 bits;
  - busy is high for exactly 129 cycles.

Source files
------------

// File: rtl/seg_serial_tx.sv
// Serial transmitter for the 64-bit segment pattern. It shifts the pattern out LSB first
// on seg_clk and then pulses seg_latch to drive the cascaded display shift registers.
module seg_serial_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] SEG_TXT,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_latch,
  output logic        busy,
  output logic        done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SHIFT_LO = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] LATCH    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] phase;
  logic [5:0]    bit_cnt;
  logic [5:0]    nxt_bit;
  logic [63:0]   shadow;
  logic          phase_end;

  assign phase_end = (phase == PH_LAST);
  assign nxt_bit   = bit_cnt + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      shadow    <= '0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves as IDLE so that a start held high re-triggers without a gap cycle
        IDLE, DONE: begin
          seg_clk   <= 1'b0;
          seg_sout  <= 1'b0;
          seg_latch <= 1'b0;
          busy      <= 1'b0;
          phase     <= '0;
          bit_cnt   <= '0;
          if (start) begin
            shadow   <= SEG_TXT;
            seg_sout <= SEG_TXT[0];
            busy     <= 1'b1;
            state    <= SHIFT_LO;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            phase   <= '0;
            seg_clk <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            phase   <= '0;
            seg_clk <= 1'b0;
            if (bit_cnt == 6'd63) begin
              seg_latch <= 1'b1;
              seg_sout  <= 1'b0;
              state     <= LATCH;
            end else begin
              bit_cnt  <= nxt_bit;
              seg_sout <= shadow[nxt_bit];
              state    <= SHIFT_LO;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        LATCH: begin
          if (phase_end) begin
            phase     <= '0;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
